reg_bank_p: RTL

//   Parametrised successor of the single 9-bit addressed register: a DEPTH x DATA_W

---
 rtl/reg_bank_pkg.sv | 10 +
 rtl/reg_bank_if.sv | 17 +
 rtl/reg_bank_mem.sv | 18 +
 rtl/reg_bank_p.sv | 59 +++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// reg_bank_pkg: shared state enum, default widths and pointer-width helper for the register bank.
package reg_bank_pkg;
    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
    localparam int DATA_W_D = 9;
    localparam int ADDR_W_D = 8;
    localparam int DEPTH_D = 256;
    function automatic int ptr_w(input int depth);
        return depth > 1 ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/reg_bank_if.sv
// reg_bank_if: control-side request bus and pipeline-side read/status signals of the register bank.
interface reg_bank_if import reg_bank_pkg::*; #(
    parameter int ADDR_W = ADDR_W_D,
    parameter int DATA_W = DATA_W_D
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] datain;
    logic wr;
    logic rd;
    logic clr;
    logic [DATA_W-1:0] dataout;
    logic dvalid;
    logic busy;
    logic err;
    modport master (output addr, datain, wr, rd, clr, input dataout, dvalid, busy, err);
    modport slave (input addr, datain, wr, rd, clr, output dataout, dvalid, busy, err);
endinterface

// File: rtl/reg_bank_mem.sv
// reg_bank_mem: unreset DEPTH x DATA_W storage, one synchronous write port, one asynchronous read port.
module reg_bank_mem #(
    parameter int DATA_W = 9,
    parameter int DEPTH = 256,
    parameter int PTR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/reg_bank_p.sv
// reg_bank_p: DEPTH x DATA_W register bank with clear sweep, 1-cycle registered reads and range error flag.
module reg_bank_p import reg_bank_pkg::*; #(
    parameter int DATA_W = DATA_W_D,
    parameter int ADDR_W = ADDR_W_D,
    parameter int DEPTH = DEPTH_D,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input logic clk,
    input logic rst,
    reg_bank_if.slave bus
);
    localparam int PTR_W = ptr_w(DEPTH);
    state_t state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] a;
    logic [DATA_W-1:0] rdata;
    logic in_rng, sweep, last, uwr, urd;
    assign a = PTR_W'(bus.addr);
    assign in_rng = {1'b0, bus.addr} < (ADDR_W + 1)'(DEPTH);
    assign sweep = state == ST_CLEAR;
    assign last = ptr == PTR_W'(DEPTH - 1);
    // clr and an active sweep both take priority over user requests
    assign uwr = !sweep && !bus.clr && bus.wr && in_rng;
    assign urd = !sweep && !bus.clr && bus.rd;
    reg_bank_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
        .clk(clk),
        .we(sweep || uwr),
        .waddr(sweep ? ptr : a),
        .wdata(sweep ? CLR_VAL : bus.datain),
        .raddr(a),
        .rdata(rdata)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_CLEAR;
            ptr <= '0;
            bus.busy <= 1'b1;
            bus.dataout <= '0;
            bus.dvalid <= 1'b0;
            bus.err <= 1'b0;
        end else begin
            bus.dvalid <= urd;
            bus.err <= (bus.wr || bus.rd) && (sweep || bus.clr || !in_rng);
            // write-first: a same-cycle write to the read address bypasses storage
            if (urd) bus.dataout <= !in_rng ? '0 : bus.wr ? bus.datain : rdata;
            if (bus.clr) begin
                state <= ST_CLEAR;
                ptr <= '0;
                bus.busy <= 1'b1;
            end else if (sweep) begin
                ptr <= last ? ptr : ptr + 1'b1;
                if (last) begin
                    state <= ST_IDLE;
                    bus.busy <= 1'b0;
                end
            end
        end
    end
endmodule
